// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store unit and the data memory responder.
// The master drives requests and takes responses; the slave is the responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_w;
    logic        req_r;
    logic [1:0]  data_size;
    logic        unsigned_value;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_w,
        output req_r,
        output data_size,
        output unsigned_value,
        output addr,
        output wdata,
        input  resp_valid,
        output resp_ready,
        input  rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_w,
        input  req_r,
        input  data_size,
        input  unsigned_value,
        input  addr,
        input  wdata,
        output resp_valid,
        input  resp_ready,
        output rdata,
        output resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering byte/half/word loads and stores after a
// fixed number of wait states, with alignment/range/opcode error reporting.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request latched, wait_cnt counting down the configured wait states
// RESP  | response presented, held until resp_ready
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    data_mem_responder_if.slave bus
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0] SZ_B      = 2'b00;
    localparam logic [1:0] SZ_H      = 2'b01;
    localparam logic [1:0] SZ_W      = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] rdata_q;

    logic [31:0] r_addr;
    logic        r_w;
    logic        r_r;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_wdata;

    logic [31:0] mem [DEPTH];

    logic             accept;
    logic             leave_pre;
    logic [31:0]      cur_addr;
    logic             cur_w;
    logic             cur_r;
    logic [1:0]       cur_size;
    logic             cur_uns;
    logic [31:0]      cur_wdata;
    logic             cur_err;
    logic [IDX_W-1:0] idx;
    logic [3:0]       lane_be;
    logic [31:0]      wdata_rep;
    logic             mem_we;
    logic [31:0]      mem_word;
    logic [31:0]      shifted;
    logic [31:0]      load_data;
    logic [31:0]      resp_data;

    assign accept = bus.req_valid && req_ready_q;

    // With no wait states the memory is touched on the accept edge itself, so the
    // live bus fields stand in for the not-yet-registered copy while in IDLE.
    always_comb begin
        cur_addr  = r_addr;
        cur_w     = r_w;
        cur_r     = r_r;
        cur_size  = r_size;
        cur_uns   = r_uns;
        cur_wdata = r_wdata;
        if (state == IDLE) begin
            cur_addr  = bus.addr;
            cur_w     = bus.req_w;
            cur_r     = bus.req_r;
            cur_size  = bus.data_size;
            cur_uns   = bus.unsigned_value;
            cur_wdata = bus.wdata;
        end
    end

    always_comb begin
        leave_pre = 1'b0;
        if (state == IDLE && accept && NO_WAIT)
            leave_pre = 1'b1;
        else if (state == WAIT && wait_cnt == 4'd0)
            leave_pre = 1'b1;
    end

    always_comb begin
        cur_err = 1'b0;
        if (cur_size == 2'b11)
            cur_err = 1'b1;
        if (cur_size == SZ_H && cur_addr[0])
            cur_err = 1'b1;
        if (cur_size == SZ_W && cur_addr[1:0] != 2'b00)
            cur_err = 1'b1;
        if (cur_addr[31:2] >= 30'(DEPTH))
            cur_err = 1'b1;
        if (cur_w == cur_r)
            cur_err = 1'b1;
    end

    assign idx = cur_addr[IDX_W+1:2];

    always_comb begin
        lane_be   = 4'b0000;
        wdata_rep = cur_wdata;
        case (cur_size)
            SZ_B: begin
                lane_be   = 4'b0001 << cur_addr[1:0];
                wdata_rep = {4{cur_wdata[7:0]}};
            end
            SZ_H: begin
                lane_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{cur_wdata[15:0]}};
            end
            SZ_W: begin
                lane_be   = 4'b1111;
                wdata_rep = cur_wdata;
            end
            default: begin
                lane_be   = 4'b0000;
                wdata_rep = cur_wdata;
            end
        endcase
    end

    assign mem_we = leave_pre && cur_w && !cur_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i])
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    assign mem_word = mem[idx];
    assign shifted  = mem_word >> {cur_addr[1:0], 3'b000};

    always_comb begin
        load_data = mem_word;
        case (cur_size)
            SZ_B:    load_data = cur_uns ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = cur_uns ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = mem_word;
        endcase
    end

    assign resp_data = (cur_err || cur_w) ? 32'h0 : load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'h0;
            r_addr       <= 32'h0;
            r_w          <= 1'b0;
            r_r          <= 1'b0;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_wdata      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        r_addr      <= bus.addr;
                        r_w         <= bus.req_w;
                        r_r         <= bus.req_r;
                        r_size      <= bus.data_size;
                        r_uns       <= bus.unsigned_value;
                        r_wdata     <= bus.wdata;
                        req_ready_q <= 1'b0;
                        if (NO_WAIT) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= resp_data;
                            resp_err_q   <= cur_err;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= resp_data;
                        resp_err_q   <= cur_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        rdata_q      <= 32'h0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.rdata      = rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios then random traffic checked
// against a byte-addressed reference memory.
module tb_data_mem_responder;
    localparam int DEPTH = 1024;
    localparam int WS    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] ref_mem [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory is a set of bytes; a transaction touches 1<<size bytes.
    task automatic model_txn(input logic w, input logic r, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er, output logic known);
        int n;
        logic [31:0] v;
        n     = 1 << sz;
        er    = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
                ((a >> 2) >= 32'(DEPTH)) || (w == r);
        rd    = 32'h0;
        known = 1'b1;
        if (er) return;
        if (w) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            return;
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (!ref_mem.exists(int'(a) + i)) known = 1'b0;
            else v[8*i +: 8] = ref_mem[int'(a) + i];
        end
        if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        rd = v;
    endtask

    task automatic drive_req(input logic w, input logic r, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid      = 1'b1;
        bus.req_w          = w;
        bus.req_r          = r;
        bus.data_size      = sz;
        bus.unsigned_value = uns;
        bus.addr           = a;
        bus.wdata          = wd;
    endtask

    task automatic scramble_req();
        bus.req_valid      = 1'b0;
        bus.req_w          = 1'($urandom);
        bus.req_r          = 1'($urandom);
        bus.data_size      = 2'($urandom);
        bus.unsigned_value = 1'($urandom);
        bus.addr           = $urandom;
        bus.wdata          = $urandom;
    endtask

    // Present a request, wait for acceptance and response, optionally stall it.
    task automatic do_txn(input logic w, input logic r, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output logic er);
        logic [31:0] m_rd;
        logic        m_er;
        logic        known;
        int          c;
        rd = 32'h0;
        er = 1'b0;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        drive_req(w, r, sz, uns, a, wd);
        c = 0;
        while (!bus.req_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        model_txn(w, r, sz, uns, a, wd, m_rd, m_er, known);
        @(negedge clk);
        scramble_req();
        c = 1;
        while (!bus.resp_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("latency", 32'(c), 32'(WS + 1));
        if (!bus.resp_valid) return;
        rd = bus.rdata;
        er = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            drive_req(1'b1, 1'b0, 2'd2, 1'b0, {a[31:2], 2'b00}, 32'h5A5A_5A5A);
            @(negedge clk);
            check("hold_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_ready", 32'(bus.req_ready), 32'd0);
            check("hold_err", 32'(bus.resp_err), 32'(m_er));
            if (known) check("hold_rdata", bus.rdata, m_rd);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_drop", 32'(bus.resp_valid), 32'd0);
        check("idle_ready", 32'(bus.req_ready), 32'd1);
        check("resp_err", 32'(er), 32'(m_er));
        if (known) check("rdata", rd, m_rd);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        w;
    logic        r;
    int          sel;
    int          acc [4];
    int          nacc;
    int          c;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_w = 1'b0; bus.req_r = 1'b0; bus.data_size = 2'b00;
        bus.unsigned_value = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.resp_ready = 1'b0;

        // reset state
        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready_low", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("rel_req_ready_high", 32'(bus.req_ready), 32'd1);

        // scenario 1
        do_txn(1, 0, 2'd2, 0, 32'h10, 32'h8000_00FF, 0, rd, er);
        check("s1_sw_rdata", rd, 32'h0);
        check("s1_sw_err", 32'(er), 32'd0);
        do_txn(0, 1, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);
        check("s1_lw", rd, 32'h8000_00FF);
        check("s1_lw_err", 32'(er), 32'd0);

        // scenario 2
        do_txn(1, 0, 2'd0, 0, 32'h11, 32'h0000_00A5, 0, rd, er);
        do_txn(0, 1, 2'd0, 0, 32'h11, 32'h0, 0, rd, er);
        check("s2_lb", rd, 32'hFFFF_FFA5);
        do_txn(0, 1, 2'd0, 1, 32'h11, 32'h0, 0, rd, er);
        check("s2_lbu", rd, 32'h0000_00A5);
        do_txn(0, 1, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);
        check("s2_lw", rd, 32'h8000_A5FF);

        // scenario 3
        do_txn(1, 0, 2'd1, 0, 32'h12, 32'h0000_8001, 0, rd, er);
        do_txn(0, 1, 2'd1, 0, 32'h12, 32'h0, 0, rd, er);
        check("s3_lh", rd, 32'hFFFF_8001);
        do_txn(0, 1, 2'd1, 1, 32'h12, 32'h0, 0, rd, er);
        check("s3_lhu", rd, 32'h0000_8001);
        do_txn(0, 1, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);
        check("s3_lw", rd, 32'h8001_A5FF);

        // scenario 4: error cases
        do_txn(0, 1, 2'd2, 0, 32'h13, 32'h0, 0, rd, er);
        check("s4_lw_mis_err", 32'(er), 32'd1); check("s4_lw_mis_rd", rd, 32'h0);
        do_txn(1, 0, 2'd1, 0, 32'h11, 32'h0000_1234, 0, rd, er);
        check("s4_sh_mis_err", 32'(er), 32'd1); check("s4_sh_mis_rd", rd, 32'h0);
        do_txn(0, 1, 2'd3, 0, 32'h10, 32'h0, 0, rd, er);
        check("s4_size3_err", 32'(er), 32'd1); check("s4_size3_rd", rd, 32'h0);
        do_txn(0, 1, 2'd2, 0, 32'(DEPTH * 4), 32'h0, 0, rd, er);
        check("s4_range_err", 32'(er), 32'd1); check("s4_range_rd", rd, 32'h0);
        do_txn(1, 1, 2'd2, 0, 32'h10, 32'hFFFF_FFFF, 0, rd, er);
        check("s4_wr_both_err", 32'(er), 32'd1); check("s4_wr_both_rd", rd, 32'h0);
        do_txn(0, 1, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);
        check("s4_lw_after", rd, 32'h8001_A5FF);
        check("s4_lw_after_err", 32'(er), 32'd0);

        // scenario 5: stalled response, ignored requests during the stall
        do_txn(0, 1, 2'd2, 0, 32'h10, 32'h0, 5, rd, er);
        check("s5_lw", rd, 32'h8001_A5FF);
        do_txn(0, 1, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);
        check("s5_lw_unchanged", rd, 32'h8001_A5FF);

        // back-to-back throughput
        @(negedge clk);
        bus.resp_ready = 1'b1;
        drive_req(0, 1, 2'd2, 0, 32'h10, 32'h0);
        nacc = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (nacc == 4) break;
            if (bus.req_ready) begin
                acc[nacc] = cyc;
                nacc++;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("tput_count", 32'(nacc), 32'd4);
        for (int i = 1; i < nacc; i++) check("tput_period", 32'(acc[i] - acc[i-1]), 32'(WS + 2));
        repeat (WS + 4) @(negedge clk);
        bus.resp_ready = 1'b0;

        // scenario 6: reset during WAIT of a store
        do_txn(1, 0, 2'd2, 0, 32'h20, 32'h1234_5678, 0, rd, er);
        @(negedge clk);
        drive_req(1, 0, 2'd2, 0, 32'h20, 32'hDEAD_BEEF);
        c = 0;
        while (!bus.req_ready && c < 50) begin @(negedge clk); c++; end
        check("s6_accept", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        scramble_req();
        rst_n = 1'b0;
        #1;
        check("s6_rst_valid", 32'(bus.resp_valid), 32'd0);
        check("s6_rst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("s6_rel_ready", 32'(bus.req_ready), 32'd1);
        do_txn(0, 1, 2'd2, 0, 32'h20, 32'h0, 0, rd, er);
        check("s6_lw", rd, 32'h1234_5678);

        // reset while a load response is pending
        @(negedge clk);
        drive_req(0, 1, 2'd2, 0, 32'h10, 32'h0);
        c = 0;
        while (!bus.req_ready && c < 50) begin @(negedge clk); c++; end
        @(negedge clk);
        scramble_req();
        c = 0;
        while (!bus.resp_valid && c < 50) begin @(negedge clk); c++; end
        check("r7_pending", 32'(bus.resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("r7_rst_valid", 32'(bus.resp_valid), 32'd0);
        check("r7_rst_rdata", bus.rdata, 32'h0);
        check("r7_rst_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(0, 1, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);
        check("r7_mem_survives", rd, 32'h8001_A5FF);

        // random traffic over a preloaded window
        for (int k = 0; k < 16; k++) do_txn(1, 0, 2'd2, 0, 32'h40 + 32'(4 * k), $urandom, 0, rd, er);
        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 9);
            a   = 32'h40 + 32'($urandom_range(0, 63));
            if (sel == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            sz  = (sel == 1) ? 2'd3 : 2'($urandom_range(0, 2));
            w   = 1'($urandom_range(0, 1));
            r   = (sel == 2) ? w : ~w;
            do_txn(w, r, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), rd, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
